// File: rtl/phy_mdio_init_if.sv
// Command and read-data handshake between the PHY init sequencer and mdio_master.
interface phy_mdio_init_if;
    logic [4:0]  cmd_phy_addr;
    logic [4:0]  cmd_reg_addr;
    logic [15:0] cmd_data;
    logic [1:0]  cmd_opcode;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;

    modport master (
        output cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode, cmd_valid, data_out_ready,
        input  cmd_ready, data_out, data_out_valid
    );

    modport slave (
        input  cmd_phy_addr, cmd_reg_addr, cmd_data, cmd_opcode, cmd_valid, data_out_ready,
        output cmd_ready, data_out, data_out_valid
    );
endinterface

// File: rtl/phy_mdio_init.sv
// Autonomous PHY bring-up: startup delay, register-table writes, BMCR soft-reset
// poll, then periodic BMSR reads reporting link state.
module phy_mdio_init #(
    parameter logic [4:0]  PHY_ADDR      = 5'h07,
    parameter logic [19:0] STARTUP_DELAY = 20'hFFFFF,
    parameter logic [23:0] POLL_INTERVAL = 24'd1250000,
    parameter logic [7:0]  RST_POLL_MAX  = 8'd16
) (
    input  logic             clk,
    input  logic             rst,
    phy_mdio_init_if.master  bus,
    output logic             init_done,
    output logic             init_error,
    output logic             link_up
);
    localparam int unsigned TBL_LAST = 5;
    localparam logic [1:0]  OP_WR    = 2'b01;
    localparam logic [1:0]  OP_RD    = 2'b10;
    localparam logic [4:0]  REG_BMCR = 5'h00;
    localparam logic [4:0]  REG_BMSR = 5'h01;

    typedef enum logic [2:0] {
        S_DELAY, S_WR_ISSUE, S_WR_GAP, S_RST_ISSUE, S_RST_RESP, S_WAIT, S_LNK_ISSUE, S_LNK_RESP
    } state_t;

    state_t      state;
    logic [2:0]  idx;
    logic [19:0] dly_cnt;
    logic [23:0] poll_cnt;
    logic [7:0]  rst_cnt;
    logic [4:0]  tbl_reg;
    logic [15:0] tbl_data;
    logic        accept;

    assign accept           = bus.cmd_valid && bus.cmd_ready;
    assign bus.cmd_phy_addr = PHY_ADDR;

    // Fixed PHY configuration table: autoneg advert, 1000BASE-T advert, page, PHY ctrl, BMCR x2
    always_comb begin
        tbl_reg  = 5'h00;
        tbl_data = 16'h0000;
        case (idx)
            3'd0:    begin tbl_reg = 5'h04; tbl_data = 16'h0DE1; end
            3'd1:    begin tbl_reg = 5'h09; tbl_data = 16'h0300; end
            3'd2:    begin tbl_reg = 5'h16; tbl_data = 16'h0000; end
            3'd3:    begin tbl_reg = 5'h10; tbl_data = 16'h7800; end
            3'd4:    begin tbl_reg = 5'h00; tbl_data = 16'h1340; end
            3'd5:    begin tbl_reg = 5'h00; tbl_data = 16'h9140; end
            default: begin tbl_reg = 5'h00; tbl_data = 16'h0000; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= S_DELAY;
            idx                <= 3'd0;
            dly_cnt            <= STARTUP_DELAY;
            poll_cnt           <= POLL_INTERVAL;
            rst_cnt            <= 8'd0;
            bus.cmd_valid      <= 1'b0;
            bus.cmd_reg_addr   <= 5'h00;
            bus.cmd_data       <= 16'h0000;
            bus.cmd_opcode     <= OP_WR;
            bus.data_out_ready <= 1'b0;
            init_done          <= 1'b0;
            init_error         <= 1'b0;
            link_up            <= 1'b0;
        end else begin
            case (state)
                S_DELAY: begin
                    if (dly_cnt == 20'd0) state <= S_WR_ISSUE;
                    else                  dly_cnt <= dly_cnt - 20'd1;
                end
                // First entry from the delay presents the command one cycle late
                S_WR_ISSUE: begin
                    if (!bus.cmd_valid) begin
                        bus.cmd_valid    <= 1'b1;
                        bus.cmd_reg_addr <= tbl_reg;
                        bus.cmd_data     <= tbl_data;
                        bus.cmd_opcode   <= OP_WR;
                    end else if (bus.cmd_ready) begin
                        if (idx == 3'(TBL_LAST)) begin
                            state            <= S_RST_ISSUE;
                            bus.cmd_reg_addr <= REG_BMCR;
                            bus.cmd_data     <= 16'h0000;
                            bus.cmd_opcode   <= OP_RD;
                        end else begin
                            bus.cmd_valid <= 1'b0;
                            idx           <= idx + 3'd1;
                            state         <= S_WR_GAP;
                        end
                    end
                end
                S_WR_GAP: begin
                    bus.cmd_valid    <= 1'b1;
                    bus.cmd_reg_addr <= tbl_reg;
                    bus.cmd_data     <= tbl_data;
                    bus.cmd_opcode   <= OP_WR;
                    state            <= S_WR_ISSUE;
                end
                S_RST_ISSUE: begin
                    if (accept) begin
                        bus.cmd_valid      <= 1'b0;
                        bus.data_out_ready <= 1'b1;
                        state              <= S_RST_RESP;
                        if (rst_cnt != 8'hFF) rst_cnt <= rst_cnt + 8'd1;
                    end
                end
                S_RST_RESP: begin
                    if (bus.data_out_valid) begin
                        bus.data_out_ready <= 1'b0;
                        if (!bus.data_out[15] || rst_cnt >= RST_POLL_MAX) begin
                            init_done  <= 1'b1;
                            init_error <= bus.data_out[15];
                            poll_cnt   <= POLL_INTERVAL;
                            state      <= S_WAIT;
                        end else begin
                            bus.cmd_valid <= 1'b1;
                            state         <= S_RST_ISSUE;
                        end
                    end
                end
                S_WAIT: begin
                    if (poll_cnt == 24'd0) begin
                        bus.cmd_valid    <= 1'b1;
                        bus.cmd_reg_addr <= REG_BMSR;
                        bus.cmd_data     <= 16'h0000;
                        bus.cmd_opcode   <= OP_RD;
                        state            <= S_LNK_ISSUE;
                    end else begin
                        poll_cnt <= poll_cnt - 24'd1;
                    end
                end
                S_LNK_ISSUE: begin
                    if (accept) begin
                        bus.cmd_valid      <= 1'b0;
                        bus.data_out_ready <= 1'b1;
                        state              <= S_LNK_RESP;
                    end
                end
                S_LNK_RESP: begin
                    if (bus.data_out_valid) begin
                        bus.data_out_ready <= 1'b0;
                        link_up            <= bus.data_out[2];
                        poll_cnt           <= POLL_INTERVAL;
                        state              <= S_WAIT;
                    end
                end
                default: state <= S_DELAY;
            endcase
        end
    end
endmodule
